iob_skid_buf: RTL
=================

# iob_skid_buf

Two-entry elastic pipeline stage with valid/ready handshake on both sides. It breaks the combinational ready path between a producer and a consumer register stage. It is inserted at datapath boundaries where a sink register, such as a plain enable-gated register, must be fed at full throughput without a combinational ready chain back to the source. Output data is always driven from a flop; input ready is always driven from a flop (gated only by `en`).

## Interface
- `DATA_W`, default 32: payload width in bits; legal range is 1 and up.
- `RST_VAL`, default 0: value of `o_data` after reset; truncated or zero-extended to `DATA_W`.
- `clk` input, 1: clock, rising edge.
- `arst` input, 1: reset, asynchronous, active-high.
- `rst` input, 1: synchronous reset, active-high; same effect as `arst` at the next edge.
- `en` input, 1: stage enable; low = stall.
- `i_valid` input, 1: upstream data valid.
- `i_ready` output, 1: stage can accept upstream data.
- `i_data` input, `DATA_W`: upstream payload.
- `o_valid` output, 1: `o_data` holds a valid word.
- `o_ready` input, 1: downstream accepts `o_data`.
- `o_data` output, `DATA_W`: downstream payload.
- `level` output, 2: number of words held (0, 1 or 2).

## Operation
- Storage:
  - main register `m_data`/`m_valid` drives `o_data`/`o_valid`;
  - skid register `s_data`/`s_valid` holds one overflow word.
- States, encoded by (`m_valid`, `s_valid`):
  - EMPTY (0,0), ONE (1,0), FULL (1,1); (0,1) is unreachable and is asserted illegal.
- Transfer definitions:
  - input transfer (IT) = `i_valid` & `i_ready`;
  - output transfer (OT) = `o_valid` & `o_ready`.
- `i_ready` = `en` & ~`s_valid`; `o_valid` = `en` & `m_valid`; `o_data` = `m_data` regardless of `en`.
- `level` = `m_valid` + `s_valid`, ungated by `en`.
- Transitions (evaluated only when `en`=1):
  - EMPTY: IT -> ONE, `m_data`<=`i_data`.
  - ONE, IT & OT: stay ONE, `m_data`<=`i_data`.
  - ONE, IT & ~OT: -> FULL, `s_data`<=`i_data`.
  - ONE, ~IT & OT: -> EMPTY.
  - FULL, OT: -> ONE, `m_data`<=`s_data`. No IT is possible in FULL because `i_ready`=0.
  - Any state, no transfer: hold.
- `en`=0: no register updates, no transfers counted, `i_ready`=`o_valid`=0.
- Ordering: words leave in arrival order; none are dropped or duplicated.
- Data registers load only on the events listed above; `s_data` may retain stale data when `s_valid`=0.

## Timing
- Reset values (`arst` or `rst`):
  - `m_valid`=`s_valid`=0;
  - `m_data`=`s_data`=`RST_VAL`;
  - hence `o_valid`=0, `i_ready`=`en`, `o_data`=`RST_VAL`, `level`=0.
- `arst` acts immediately. `rst` acts at the next rising edge and overrides every transfer in that cycle; words presented in that cycle are lost, and upstream must not count them as accepted.
- Reset mid-operation discards both held words.
- Latency: a word accepted at edge N is on `o_data` with `o_valid`=1 after edge N (visible in cycle N+1).
- Throughput: 1 word/cycle in steady state with `o_ready`=1.
- `i_ready` deasserts only in the cycle after the stage enters FULL. `i_ready` has no combinational path from `o_ready`.
- Downstream stall: the upstream word in flight at the stall edge lands in skid. The next word sees `i_ready`=0.
- `o_data` stays stable while `o_valid`=1 and `o_ready`=0.

## Test plan
- Reset: assert `arst` with `RST_VAL`=0xA5, `DATA_W`=8 -> `o_data`=0xA5, `o_valid`=0, `level`=0, `i_ready`=1 with `en`=1.
- Streaming: `o_ready`=1; 8 back-to-back words 0x00..0x07 on consecutive edges -> `o_data` sequence 0x00..0x07 one cycle later, no bubbles, `level` stays 1.
- Stall/skid: stream 0x10, 0x11, 0x12; drop `o_ready` just before the 0x11 edge -> `level`=2, `i_ready`=0, `o_data`=0x10 held. Raise `o_ready` -> 0x10, 0x11, 0x12 emerge in order with none lost.
- Simultaneous in/out in ONE: feed 0x20 then 0x21 with `o_ready`=1 at the same edge -> `level` stays 1, `o_data`=0x21 next cycle.
- Enable stall: in FULL with 0x30 and 0x31, hold `en`=0 for 3 cycles with `o_ready`=1 -> `o_valid`=0, `i_ready`=0, `level`=2 throughout. Restore `en`=1 -> 0x30 then 0x31 delivered.
- Sync reset mid-operation: FULL, assert `rst` one cycle with `i_valid`=1, `i_data`=0x40 -> next cycle `level`=0, `o_valid`=0, `o_data`=`RST_VAL`; 0x40 is not delivered.

Source files
------------

// File: rtl/iob_skid_buf.sv
// Two-entry elastic stage: registered o_data and registered i_ready, full throughput.
// The skid register absorbs the word in flight when the consumer stalls.
module iob_skid_buf #(
  parameter int unsigned DATA_W  = 32,
  parameter int unsigned RST_VAL = 0
) (
  input  logic              clk,
  input  logic              arst,
  input  logic              rst,
  input  logic              en,
  input  logic              i_valid,
  output logic              i_ready,
  input  logic [DATA_W-1:0] i_data,
  output logic              o_valid,
  input  logic              o_ready,
  output logic [DATA_W-1:0] o_data,
  output logic [1:0]        level
);

  localparam logic [DATA_W-1:0] RST_D = DATA_W'(RST_VAL);

  // Encoding is {m_valid, s_valid}; 2'b01 is never entered.
  typedef enum logic [1:0] {
    EMPTY = 2'b00,
    ONE   = 2'b10,
    FULL  = 2'b11
  } state_t;

  state_t            state, state_nxt;
  logic [DATA_W-1:0] m_data, s_data;
  logic              m_valid, s_valid;
  logic              it, ot;
  logic              m_load_in, m_load_skid, s_load_in;

  assign m_valid = state[1];
  assign s_valid = state[0];

  assign i_ready = en & ~s_valid;
  assign o_valid = en & m_valid;
  assign o_data  = m_data;
  assign level   = {1'b0, m_valid} + {1'b0, s_valid};

  assign it = i_valid & i_ready;
  assign ot = o_valid & o_ready;

  always_comb begin
    state_nxt   = state;
    m_load_in   = 1'b0;
    m_load_skid = 1'b0;
    s_load_in   = 1'b0;
    case (state)
      EMPTY: begin
        if (it) begin
          state_nxt = ONE;
          m_load_in = 1'b1;
        end
      end
      ONE: begin
        if (it && ot) begin
          m_load_in = 1'b1;
        end else if (it) begin
          state_nxt = FULL;
          s_load_in = 1'b1;
        end else if (ot) begin
          state_nxt = EMPTY;
        end
      end
      FULL: begin
        // i_ready is low here, so only the drain path exists.
        if (ot) begin
          state_nxt   = ONE;
          m_load_skid = 1'b1;
        end
      end
      default: state_nxt = EMPTY;
    endcase
  end

  always_ff @(posedge clk or posedge arst) begin
    if (arst) begin
      state  <= EMPTY;
      m_data <= RST_D;
      s_data <= RST_D;
    end else if (rst) begin
      state  <= EMPTY;
      m_data <= RST_D;
      s_data <= RST_D;
    end else begin
      state <= state_nxt;
      if (m_load_in) begin
        m_data <= i_data;
      end else if (m_load_skid) begin
        m_data <= s_data;
      end
      if (s_load_in) begin
        s_data <= i_data;
      end
    end
  end

  a_no_skid_only : assert property (@(posedge clk) disable iff (arst) state != 2'b01);

endmodule
